// File: rtl/riscv_mem_arb_pkg.sv
// Shared types and widths for the on-chip RAM s2 port arbiter.
// Build option: ARB_FIXED_PRIORITY_EN selects fixed m0-first priority.
package riscv_mem_arb_pkg;

    localparam int ARB_ADDR_W = 13;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef logic req_id_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_BE_W-1:0]   byteenable;
        logic                  read;
        logic                  write;
        logic [ARB_DATA_W-1:0] writedata;
    } av_req_t;

endpackage

// File: rtl/riscv_mem_arb_grant.sv
// Per-cycle grant logic: hold-limited round-robin, or fixed m0 priority
// when ARB_FIXED_PRIORITY_EN is defined.
module riscv_mem_arb_grant
    import riscv_mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

`ifdef ARB_FIXED_PRIORITY_EN

    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        grant0 = req0 & ~reset;
        grant1 = req1 & ~req0 & ~reset;
    end

`else

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    req_id_t    owner, owner_d;
    logic [3:0] hold_cnt, hold_d;
    logic       req_own, req_oth, keep;

    // A zero count means the owner has no live run, so contention goes
    // to the other side; this is what lets m0 win first after reset.
    assign req_own = owner ? req1 : req0;
    assign req_oth = owner ? req0 : req1;
    assign keep    = (hold_cnt != 4'd0) && (hold_cnt < HOLD_MAX);

    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        owner_d = owner;
        hold_d  = hold_cnt;
        if (reset) begin
            hold_d = hold_cnt;
        end else if (req_own && (!req_oth || keep)) begin
            if (owner) grant1 = 1'b1;
            else       grant0 = 1'b1;
            hold_d = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 4'd1;
        end else if (req_oth) begin
            if (owner) grant0 = 1'b1;
            else       grant1 = 1'b1;
            owner_d = ~owner;
            hold_d  = 4'd1;
        end else begin
            hold_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= 1'b1;
            hold_cnt <= 4'd0;
        end else begin
            owner    <= owner_d;
            hold_cnt <= hold_d;
        end
    end

`endif

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// Two-requester arbiter for the on-chip RAM s2 port with 1-cycle read return.
// Build option: ARB_FIXED_PRIORITY_EN (fixed m0 priority instead of round-robin).
module riscv_mem_port_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    av_req_t r0, r1, sel;
    logic    grant0, grant1, rd_acc;
    logic    rd_pend;
    req_id_t rd_src;

    assign r0 = '{address: m0_address, byteenable: m0_byteenable,
                  read: m0_read, write: m0_write, writedata: m0_writedata};
    assign r1 = '{address: m1_address, byteenable: m1_byteenable,
                  read: m1_read, write: m1_write, writedata: m1_writedata};

    riscv_mem_arb_grant #(.MAX_HOLD(MAX_HOLD)) u_grant (
        .clk    (clk),
        .reset  (reset),
        .req0   (m0_read | m0_write),
        .req1   (m1_read | m1_write),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign sel = grant1 ? r1 : r0;

    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    assign mem_address    = sel.address;
    assign mem_byteenable = sel.byteenable;
    assign mem_writedata  = sel.writedata;
    assign mem_chipselect = grant0 | grant1;
    assign mem_write      = mem_chipselect & sel.write;
    assign mem_clken      = 1'b1;

    // Read+write together counts as a write, so it never returns data.
    assign rd_acc = mem_chipselect & sel.read & ~sel.write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_src  <= 1'b0;
        end else begin
            rd_pend <= rd_acc;
            rd_src  <= grant1;
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend & (rd_src == 1'b0);
    assign m1_readdatavalid = rd_pend & (rd_src == 1'b1);

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Directed self-checking bench for riscv_mem_port_arbiter with a RAM model.
// Build option: ARB_FIXED_PRIORITY_EN switches the arbitration checks.
module tb_riscv_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_mem_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // RAM model: registered address, unregistered read data.
    logic [31:0] ram [8192];
    logic [12:0] addr_q = '0;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            addr_q <= mem_address;
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end

    assign mem_readdata = ram[addr_q];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        m0_read = rd; m0_write = wr; m0_address = a;
        m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        m1_read = rd; m1_write = wr; m1_address = a;
        m1_byteenable = be; m1_writedata = wd;
    endtask

    task automatic idle();
        drv0(0, 0, 13'h0, 4'h0, 32'h0);
        drv1(0, 0, 13'h0, 4'h0, 32'h0);
    endtask

    initial begin : main
        int g, pg;
        reset = 1'b1;
        idle();
        #2;
        drv0(1, 0, 13'h10, 4'hF, 32'h0);
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_write", mem_write, 0);
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("idle_m0_wait", m0_waitrequest, 1);
        chk("idle_m1_wait", m1_waitrequest, 1);
        chk("idle_cs", mem_chipselect, 0);
        chk("idle_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        chk("clken", mem_clken, 1);
        tick();

        // Preload 0x20 and write 0x10 from m0.
        drv0(0, 1, 13'h20, 4'hF, 32'h11223344);
        #1;
        chk("wr20_grant", m0_waitrequest, 0);
        chk("wr20_mwrite", mem_write, 1);
        chk("wr20_addr", mem_address, 13'h20);
        tick();
        drv0(0, 1, 13'h10, 4'hF, 32'hDEADBEEF);
        #1;
        chk("wr10_data", mem_writedata, 32'hDEADBEEF);
        tick();

        // m1 reads the word m0 just wrote.
        idle();
        drv1(1, 0, 13'h10, 4'hF, 32'h0);
        #1;
        chk("m1rd_grant", m1_waitrequest, 0);
        chk("m1rd_mwrite", mem_write, 0);
        chk("m1rd_addr", mem_address, 13'h10);
        chk("wr_no_rdv", m0_readdatavalid, 0);
        tick();
        idle();
        #1;
        chk("m1rd_rdv", m1_readdatavalid, 1);
        chk("m1rd_data", m1_readdata, 32'hDEADBEEF);
        chk("m1rd_m0rdv", m0_readdatavalid, 0);
        tick();

        // Byte-lane write then readback.
        drv0(0, 1, 13'h20, 4'h2, 32'h0000AB00);
        #1;
        chk("be_be", mem_byteenable, 4'h2);
        tick();
        drv0(1, 0, 13'h20, 4'hF, 32'h0);
        #1;
        chk("be_rd_grant", m0_waitrequest, 0);
        tick();
        idle();
        #1;
        chk("be_rdv", m0_readdatavalid, 1);
        chk("be_data", m0_readdata, 32'h1122AB44);
        chk("be_m1rdv", m1_readdatavalid, 0);
        tick();

        // Continuous contention: m0 reads 0x10, m1 reads 0x20.
        pg = 0;
        for (int i = 0; i <= 12; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            g = 0;
`else
            g = ((i / 4) % 2 == 0) ? 1 : 0;
`endif
            if (i < 12) begin
                drv0(1, 0, 13'h10, 4'hF, 32'h0);
                drv1(1, 0, 13'h20, 4'hF, 32'h0);
            end else begin
                idle();
            end
            #1;
            if (i < 12) begin
                chk($sformatf("rr%0d_m0wait", i), m0_waitrequest, g != 0);
                chk($sformatf("rr%0d_m1wait", i), m1_waitrequest, g != 1);
            end
            if (i > 0) begin
                chk($sformatf("rr%0d_m0rdv", i), m0_readdatavalid, pg == 0);
                chk($sformatf("rr%0d_m1rdv", i), m1_readdatavalid, pg == 1);
                chk($sformatf("rr%0d_data", i), mem_readdata,
                    (pg == 0) ? 32'hDEADBEEF : 32'h1122AB44);
            end
            pg = g;
            tick();
        end

        // Reset with an m1 read in flight.
        idle();
        drv1(1, 0, 13'h10, 4'hF, 32'h0);
        #1;
        chk("rstf_m1_grant", m1_waitrequest, 0);
        tick();
        reset = 1'b1;
        drv0(1, 0, 13'h10, 4'hF, 32'h0);
        #1;
        chk("rstf_m1rdv", m1_readdatavalid, 0);
        chk("rstf_m0wait", m0_waitrequest, 1);
        chk("rstf_m1wait", m1_waitrequest, 1);
        chk("rstf_cs", mem_chipselect, 0);
        tick();
        chk("rstf_m1rdv2", m1_readdatavalid, 0);
        reset = 1'b0;
        drv1(1, 0, 13'h20, 4'hF, 32'h0);
        #1;
        chk("post_rst_m0win", m0_waitrequest, 0);
        chk("post_rst_m1wait", m1_waitrequest, 1);
        tick();
        idle();
        #1;
        chk("post_rst_m0rdv", m0_readdatavalid, 1);
        chk("post_rst_m1rdv", m1_readdatavalid, 0);
        chk("post_rst_data", m0_readdata, 32'hDEADBEEF);
        tick();

`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 10; i++) begin
            drv0(1, 0, 13'h10, 4'hF, 32'h0);
            drv1(1, 0, 13'h20, 4'hF, 32'h0);
            #1;
            chk($sformatf("fp%0d_m1wait", i), m1_waitrequest, 1);
            tick();
        end
        drv0(0, 0, 13'h0, 4'h0, 32'h0);
        #1;
        chk("fp_m1_grant", m1_waitrequest, 0);
        tick();
`else
        // m0 alone past MAX_HOLD, then m1 must win immediately.
        for (int i = 0; i < 6; i++) begin
            drv0(1, 0, 13'h10, 4'hF, 32'h0);
            #1;
            chk($sformatf("sat%0d_m0wait", i), m0_waitrequest, 0);
            tick();
        end
        drv1(1, 0, 13'h20, 4'hF, 32'h0);
        #1;
        chk("sat_m1_grant", m1_waitrequest, 0);
        chk("sat_m0_wait", m0_waitrequest, 1);
        tick();
`endif
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
